// File: rtl/l1_load_miss_queue_pkg.sv
// Shared types for the L1 load miss queue.
// Entry i of the queue belongs to hardware thread i.
package l1_load_miss_queue_pkg;

   localparam int THREADS_PER_CORE = 4;

   typedef logic [25:0] cache_line_index_t;
   typedef logic [1:0] local_thread_idx_t;
   typedef logic [1:0] l1_miss_entry_idx_t;
   typedef logic [THREADS_PER_CORE-1:0] local_thread_bitmap_t;

   typedef struct packed {
      logic valid;
      logic request_sent;
      local_thread_bitmap_t waiting_threads;
      cache_line_index_t address;
      logic sync;
   } miss_entry_t;

   function automatic local_thread_bitmap_t thread_onehot(
      input local_thread_idx_t idx
   );
      thread_onehot = local_thread_bitmap_t'(1) << idx;
   endfunction

endpackage

// File: rtl/l1_load_miss_queue_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after
// the priority slot; priority moves past the grant on update_lru.
module rr_arbiter #(
   parameter int NUM_REQUESTERS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic update_lru,
   output logic [NUM_REQUESTERS-1:0] grant_oh
);

   localparam int W = $clog2(NUM_REQUESTERS);

   logic [W-1:0] prio_q;
   logic [W-1:0] prio_d;
   logic [W-1:0] grant_idx;
   logic [W-1:0] slot;
   logic found;

   // NUM_REQUESTERS is a power of two, so slot arithmetic wraps
   always_comb begin
      grant_oh = '0;
      grant_idx = '0;
      found = 1'b0;
      slot = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         slot = prio_q + W'(k);
         if (!found && request[slot]) begin
            found = 1'b1;
            grant_idx = slot;
            grant_oh[slot] = 1'b1;
         end
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (update_lru && found)
         prio_d = grant_idx + W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prio_q <= '0;
      else
         prio_q <= prio_d;
   end

endmodule

// File: rtl/l1_load_miss_queue.sv
// Tracks outstanding L1 load misses, combines same-line misses,
// feeds L2 requests in round-robin order and wakes threads on fill.
module l1_load_miss_queue
   import l1_load_miss_queue_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic cache_miss,
   input  logic [25:0] cache_miss_adr,
   input  logic [1:0] cache_miss_thread_idx,
   input  logic cache_miss_sync,
   output logic dequeue_ready,
   input  logic dequeue_ack,
   output logic [25:0] dequeue_adr,
   output logic [1:0] dequeue_idx,
   output logic dequeue_sync,
   input  logic l2_response_valid,
   input  logic [1:0] l2_response_idx,
   output logic [3:0] wake_bitmap
);

   localparam int N = THREADS_PER_CORE;

   logic [N-1:0] pending;
   logic [N-1:0] combine_hit;
   logic [N-1:0] grant_oh;
   logic [N-1:0] entry_sync;
   local_thread_bitmap_t entry_wait [N];
   cache_line_index_t entry_adr [N];
   local_thread_bitmap_t miss_oh;
   logic do_alloc;
   logic do_ack;

   assign miss_oh = thread_onehot(cache_miss_thread_idx);
   assign do_alloc = cache_miss && !(|combine_hit);
   assign dequeue_ready = |pending;
   assign do_ack = dequeue_ack && dequeue_ready;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : gen_entry
         miss_entry_t entry_q;
         miss_entry_t entry_d;
         logic freeing;

         assign freeing = l2_response_valid
            && l2_response_idx == l1_miss_entry_idx_t'(i);

         // an entry being filled this cycle cannot absorb a new miss
         assign combine_hit[i] = entry_q.valid
            && entry_q.address == cache_miss_adr
            && !entry_q.sync
            && !cache_miss_sync
            && !freeing;

         always_comb begin
            entry_d = entry_q;
            if (freeing)
               entry_d.valid = 1'b0;
            if (do_ack && grant_oh[i])
               entry_d.request_sent = 1'b1;
            if (cache_miss && combine_hit[i])
               entry_d.waiting_threads = entry_q.waiting_threads | miss_oh;
            if (do_alloc
               && cache_miss_thread_idx == local_thread_idx_t'(i)) begin
               entry_d.valid = 1'b1;
               entry_d.request_sent = 1'b0;
               entry_d.waiting_threads = miss_oh;
               entry_d.address = cache_miss_adr;
               entry_d.sync = cache_miss_sync;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               entry_q <= '0;
            else
               entry_q <= entry_d;
         end

         assign pending[i] = entry_q.valid && !entry_q.request_sent;
         assign entry_sync[i] = entry_q.sync;
         assign entry_wait[i] = entry_q.waiting_threads;
         assign entry_adr[i] = entry_q.address;
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQUESTERS(N)
   ) u_arb (
      .clk(clk),
      .reset(reset),
      .request(pending),
      .update_lru(do_ack),
      .grant_oh(grant_oh)
   );

   always_comb begin
      dequeue_adr = '0;
      dequeue_idx = '0;
      dequeue_sync = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (grant_oh[k]) begin
            dequeue_adr = dequeue_adr | entry_adr[k];
            dequeue_idx = dequeue_idx | l1_miss_entry_idx_t'(k);
            dequeue_sync = dequeue_sync | entry_sync[k];
         end
      end
   end

   assign wake_bitmap = l2_response_valid
      ? entry_wait[l2_response_idx] : '0;

endmodule

// File: tb/tb_l1_load_miss_queue.sv
// Scoreboard bench for the L1 load miss queue: expected L2 requests
// are queued at miss time and matched as the queue dequeues them.
module tb_l1_load_miss_queue;

   typedef struct packed {
      logic [1:0] idx;
      logic [25:0] adr;
      logic sync;
   } deq_t;

   logic clk = 1'b0;
   logic reset;
   logic cache_miss;
   logic [25:0] cache_miss_adr;
   logic [1:0] cache_miss_thread_idx;
   logic cache_miss_sync;
   logic dequeue_ready;
   logic dequeue_ack;
   logic [25:0] dequeue_adr;
   logic [1:0] dequeue_idx;
   logic dequeue_sync;
   logic l2_response_valid;
   logic [1:0] l2_response_idx;
   logic [3:0] wake_bitmap;

   int checks = 0;
   int errors = 0;
   deq_t exp_q [$];

   always #5 clk = ~clk;

   l1_load_miss_queue dut (
      .clk(clk),
      .reset(reset),
      .cache_miss(cache_miss),
      .cache_miss_adr(cache_miss_adr),
      .cache_miss_thread_idx(cache_miss_thread_idx),
      .cache_miss_sync(cache_miss_sync),
      .dequeue_ready(dequeue_ready),
      .dequeue_ack(dequeue_ack),
      .dequeue_adr(dequeue_adr),
      .dequeue_idx(dequeue_idx),
      .dequeue_sync(dequeue_sync),
      .l2_response_valid(l2_response_valid),
      .l2_response_idx(l2_response_idx),
      .wake_bitmap(wake_bitmap)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // alloc=1 means a fresh entry (and hence an L2 request) is expected
   task automatic miss(input logic [1:0] t, input logic [25:0] a,
                       input logic s, input logic alloc);
      cache_miss = 1'b1;
      cache_miss_thread_idx = t;
      cache_miss_adr = a;
      cache_miss_sync = s;
      if (alloc) exp_q.push_back('{idx: t, adr: a, sync: s});
      step();
      cache_miss = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int d = 0; d < n; d++) begin
         int waited = 0;
         int hit = -1;
         while (!dequeue_ready && waited < 20) begin
            step();
            waited++;
         end
         check("deq_ready", 32'(dequeue_ready), 32'd1);
         if (dequeue_ready) begin
            for (int j = 0; j < exp_q.size(); j++)
               if (hit < 0 && exp_q[j].idx == dequeue_idx
                   && exp_q[j].adr == dequeue_adr
                   && exp_q[j].sync == dequeue_sync)
                  hit = j;
            check("deq_match", {dequeue_idx, dequeue_sync, 3'b0,
                  dequeue_adr}, (hit >= 0) ? {dequeue_idx,
                  dequeue_sync, 3'b0, dequeue_adr} : 32'hdead_beef);
            if (hit >= 0) exp_q.delete(hit);
            dequeue_ack = 1'b1;
            step();
            dequeue_ack = 1'b0;
         end
      end
   endtask

   task automatic respond(input logic [1:0] idx, input logic [3:0] w);
      l2_response_valid = 1'b1;
      l2_response_idx = idx;
      #2;
      check("wake", 32'(wake_bitmap), 32'(w));
      step();
      l2_response_valid = 1'b0;
      #1;
      check("wake_clr", 32'(wake_bitmap), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      cache_miss = 1'b0;
      cache_miss_adr = '0;
      cache_miss_thread_idx = '0;
      cache_miss_sync = 1'b0;
      dequeue_ack = 1'b0;
      l2_response_valid = 1'b0;
      l2_response_idx = '0;
      step();
      step();
      reset = 1'b0;
      step();
      check("rst_ready", 32'(dequeue_ready), 32'd0);
      check("rst_wake", 32'(wake_bitmap), 32'd0);

      miss(2'd0, 26'h123, 1'b0, 1'b1);
      miss(2'd1, 26'h1b2, 1'b0, 1'b1);
      check("two_ready", 32'(dequeue_ready), 32'd1);
      drain(2);
      check("two_idle", 32'(dequeue_ready), 32'd0);

      miss(2'd2, 26'h1b2, 1'b0, 1'b0);
      check("comb_idle", 32'(dequeue_ready), 32'd0);
      respond(2'd1, 4'b0110);
      respond(2'd0, 4'b0001);

      miss(2'd0, 26'ha12, 1'b1, 1'b1);
      miss(2'd1, 26'ha12, 1'b0, 1'b1);
      drain(2);
      check("sync_idle", 32'(dequeue_ready), 32'd0);
      respond(2'd0, 4'b0001);
      respond(2'd1, 4'b0010);

      miss(2'd2, 26'ha12, 1'b0, 1'b1);
      miss(2'd3, 26'ha12, 1'b1, 1'b1);
      drain(2);
      respond(2'd2, 4'b0100);
      respond(2'd3, 4'b1000);

      // fill and new miss on different entries in one cycle
      miss(2'd0, 26'h55, 1'b0, 1'b1);
      drain(1);
      l2_response_valid = 1'b1;
      l2_response_idx = 2'd0;
      cache_miss = 1'b1;
      cache_miss_thread_idx = 2'd1;
      cache_miss_adr = 26'h77;
      cache_miss_sync = 1'b0;
      exp_q.push_back('{idx: 2'd1, adr: 26'h77, sync: 1'b0});
      #2;
      check("same_wake", 32'(wake_bitmap), 32'b0001);
      step();
      l2_response_valid = 1'b0;
      cache_miss = 1'b0;
      check("same_ready", 32'(dequeue_ready), 32'd1);
      drain(1);
      respond(2'd1, 4'b0010);

      // same line freed this cycle: must allocate, not combine
      miss(2'd2, 26'h99, 1'b0, 1'b1);
      drain(1);
      l2_response_valid = 1'b1;
      l2_response_idx = 2'd2;
      cache_miss = 1'b1;
      cache_miss_thread_idx = 2'd3;
      cache_miss_adr = 26'h99;
      cache_miss_sync = 1'b0;
      exp_q.push_back('{idx: 2'd3, adr: 26'h99, sync: 1'b0});
      #2;
      check("free_wake", 32'(wake_bitmap), 32'b0100);
      step();
      l2_response_valid = 1'b0;
      cache_miss = 1'b0;
      check("free_ready", 32'(dequeue_ready), 32'd1);
      drain(1);
      respond(2'd3, 4'b1000);

      // combine before the request has gone out
      miss(2'd0, 26'h200, 1'b0, 1'b1);
      miss(2'd1, 26'h200, 1'b0, 1'b0);
      drain(1);
      check("pre_idle", 32'(dequeue_ready), 32'd0);
      respond(2'd0, 4'b0011);

      check("sb_empty", 32'(exp_q.size()), 32'd0);

      // reset with work outstanding
      miss(2'd0, 26'h300, 1'b0, 1'b0);
      miss(2'd2, 26'h301, 1'b0, 1'b0);
      check("mid_ready", 32'(dequeue_ready), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(dequeue_ready), 32'd0);
      step();
      reset = 1'b0;
      step();
      check("post_rst_ready", 32'(dequeue_ready), 32'd0);
      check("post_rst_wake", 32'(wake_bitmap), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
